// File: rtl/seq_pkg.sv
// seq_pkg: shared constants and helpers for the serial sequence detector
package seq_pkg;
  localparam int SEQ_LEN = 8;
  localparam int CNT_W = 4;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] lim);
    return (c >= lim) ? lim : c + 1'b1;
  endfunction
endpackage

// File: rtl/shift_reg_n.sv
// shift_reg_n: LEN-bit serial-in shift register, clr has priority over en
//   clk, rst_n (async active-low), en (shift sin in at LSB), clr (sync clear), q (contents)
module shift_reg_n #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr,
  input  logic           sin,
  output logic [LEN-1:0] q
);
  logic [LEN-1:0] q_q, q_d;
  always_comb q_d = clr ? '0 : en ? {q_q[LEN-2:0], sin} : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/seq_8_detector.sv
// seq_8_detector: programmable serial sequence detector with overlapping matches
//   clk, rst_n (async active-low), load (1 = shift din into pattern, 0 = detect),
//   din (serial data), dout (registered one-cycle match pulse)
module seq_8_detector
  import seq_pkg::*;
#(
  parameter int LEN = SEQ_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic din,
  output logic dout
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LEN);
  logic [LEN-1:0] pat, hist, hist_n;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic dout_q, dout_d;
  shift_reg_n #(.LEN(LEN)) u_pat (
    .clk(clk), .rst_n(rst_n), .en(load), .clr(1'b0), .sin(din), .q(pat)
  );
  shift_reg_n #(.LEN(LEN)) u_hist (
    .clk(clk), .rst_n(rst_n), .en(!load), .clr(load), .sin(din), .q(hist)
  );
  // Counter gates detection until a full window has arrived since load fell,
  // so the zero-cleared history cannot match a zero pattern early.
  always_comb begin
    hist_n = {hist[LEN-2:0], din};
    cnt_n = sat_inc(cnt_q, FULL);
    cnt_d = load ? '0 : cnt_n;
    dout_d = !load && (cnt_n == FULL) && (hist_n == pat);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dout_q <= dout_d;
    end
  assign dout = dout_q;
endmodule

// File: tb/tb_seq_8_detector.sv
// tb_seq_8_detector: directed self-checking bench for seq_8_detector
module tb_seq_8_detector;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, din = 1'b0;
  logic dout;
  int checks = 0, errors = 0;
  seq_8_detector dut (.clk(clk), .rst_n(rst_n), .load(load), .din(din), .dout(dout));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic ld, input logic d);
    load = ld;
    din = d;
    @(posedge clk);
    #1;
  endtask
  task automatic regs(input string tag, input logic [7:0] p, input logic [7:0] h, input logic [3:0] c, input logic o);
    chk({tag, ".pat"}, 32'(dut.pat), 32'(p));
    chk({tag, ".hist"}, 32'(dut.hist), 32'(h));
    chk({tag, ".cnt"}, 32'(dut.cnt_q), 32'(c));
    chk({tag, ".dout"}, 32'(dout), 32'(o));
  endtask
  initial begin
    logic [7:0] aa;
    aa = 8'hAA;
    #1;
    regs("rst0", 8'h00, 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(i < 16, (i / 4) % 2 == 1);
      chk("rst_hold.dout", 32'(dout), 32'd0);
    end
    regs("rst_hold", 8'h00, 8'h00, 4'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 7; i >= 0; i--) step(1'b1, aa[i]);
    regs("load_aa", 8'hAA, 8'h00, 4'd0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, aa[i]);
      chk("aa_bit", 32'(dout), 32'(i == 0));
    end
    regs("aa_match", 8'hAA, 8'hAA, 4'd8, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i % 2) == 0);
      chk("aa_overlap", 32'(dout), 32'(i % 2));
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    regs("load_00", 8'h00, 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0);
      chk("zero_pre", 32'(dout), 32'd0);
    end
    step(1'b0, 1'b0);
    regs("zero_8th", 8'h00, 8'h00, 4'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("zero_run", 32'(dout), 32'd1);
    end
    step(1'b1, 1'b0);
    regs("reload", 8'h00, 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0);
      chk("reload_pre", 32'(dout), 32'd0);
    end
    step(1'b0, 1'b0);
    chk("reload_8th", 32'(dout), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst.dout", 32'(dout), 32'd0);
    regs("async_rst", 8'h00, 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    regs("post_rst", 8'h00, 8'h00, 4'd1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
